tl_rx_credits_received_tracker: RTL and testbench
=================================================

TL_RX_CREDITS_RECEIVED_TRACKER -- requirements
Module: tl_rx_credits_received_tracker

Interface
REQ-001 SHALL have parameter BUFFER_IN_DW_WIDTH, default 10, the TLP payload length field width in DW (0 encodes 1024 DW).
REQ-002 SHALL have parameter RCV_HDR_CREDS_WIDTH, default 12, the width of each header CREDITS_RECEIVED counter.
REQ-003 SHALL have parameter RCV_DATA_CREDS_WIDTH, default 16, the width of each data CREDITS_RECEIVED counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 Ports SHALL be:
- tlp_start  in  1  header accepted; capture typ/len.
- buffer_typ  in  2  00 P, 01 NP, 10 CPL, 11 none.
- tlp_has_data  in  1  TLP carries payload.
- buffer_in_dw  in  BUFFER_IN_DW_WIDTH  payload length in DW.
- tlp_end  in  1  TLP complete; verdict valid.
- tlp_drop  in  1  TLP discarded (overflow or other error); qualified by tlp_end.
- fc_init  in  1  DLL FC init pulse; clears counters.
- p_rcv_hdr, np_rcv_hdr, cpl_rcv_hdr  out  RCV_HDR_CREDS_WIDTH  header CREDITS_RECEIVED.
- p_rcv_data, np_rcv_data, cpl_rcv_data  out  RCV_DATA_CREDS_WIDTH  data CREDITS_RECEIVED.
- pending_typ  out  2  type of the in-flight TLP.
- pending_data_creds  out  9  data credits of the in-flight TLP.
- busy  out  1  a TLP is in flight.
- protocol_error  out  1  one-cycle pulse on a handshake violation.

Function
REQ-006 The FSM SHALL have two states: IDLE and PENDING.
REQ-007 In IDLE, tlp_start with buffer_typ!=11 SHALL register the type and credit cost and move to PENDING.
- tlp_start with buffer_typ==11 SHALL be ignored.
REQ-008 Credit cost SHALL be 1 header credit plus, when tlp_has_data, ceil(len/4) data credits, where len = buffer_in_dw, or 1024 when buffer_in_dw==0.
- Range: 1..256 data credits; 0 when tlp_has_data=0.
REQ-009 In PENDING, tlp_end with tlp_drop=0 SHALL add the cost to the selected type's counters on that clock edge and return to IDLE.
- The update is visible one cycle after tlp_end.
REQ-010 In PENDING, tlp_end with tlp_drop=1 SHALL return to IDLE with all counters unchanged.
REQ-011 tlp_end and tlp_start in the same cycle while PENDING SHALL commit the current TLP and capture the new one, staying in PENDING with no bubble.
REQ-012 tlp_start while PENDING without tlp_end, and tlp_end in IDLE, SHALL each pulse protocol_error for one cycle.
- In both cases state and counters are unchanged, and the new tlp_start is ignored.
REQ-013 Counters SHALL add modulo 2^width (natural wrap, no saturation) and hold in unscaled credit units.
REQ-014 fc_init SHALL clear all six counters, force IDLE, and take priority over a simultaneous commit.
REQ-015 busy SHALL equal (state==PENDING).
- pending_typ and pending_data_creds are registered and hold their last value in IDLE.

Reset
REQ-016 On rst, all counters SHALL be 0, pending_typ=11, pending_data_creds=0, busy=0, protocol_error=0, and the state IDLE.
REQ-017 rst during PENDING SHALL discard the in-flight TLP without any counter update.
- rst takes priority over fc_init, tlp_start and tlp_end.

Configuration
REQ-018 Macro TL_RX_RCV_DROP_STATS_EN, when defined, SHALL add output drop_count (16 bits).
- It increments on each tlp_end with tlp_drop=1 in PENDING, saturates at 0xFFFF, and clears on rst or fc_init.
- When undefined, the port and logic are absent and all other behaviour is identical.

Structure
REQ-019 A shared package SHALL hold:
- the buffer_typ encodings (P/NP/CPL/NONE);
- the FSM state encoding;
- the DW-per-data-credit constant (4);
- the 1024-DW maximum-payload constant.
REQ-020 A single sub-module, tl_rx_rcv_credit_counter (one header/data counter pair with add-enable and clear), SHALL be instantiated once per type.

Verification
REQ-021 The bench SHALL cover these scenarios:
- P TLP, len=5, has_data, no drop: p_rcv_hdr 0->1 and p_rcv_data 0->2 one cycle after tlp_end; others unchanged.
- NP TLP, len=0, has_data: np_rcv_data +256; CPL with has_data=0: cpl_rcv_hdr +1, cpl_rcv_data +0.
- CPL TLP, len=8, tlp_drop=1: counters unchanged; drop_count=1 when TL_RX_RCV_DROP_STATS_EN is defined.
- p_rcv_data preset to 0xFFFF, then P TLP with len=4: p_rcv_data wraps to 0x0000.
- Back-to-back TLPs with tlp_end and tlp_start in the same cycle: both committed, busy stays 1; second tlp_start without tlp_end: protocol_error pulses once.
- fc_init coincident with tlp_end: all counters 0, no commit; rst mid-PENDING: busy=0 and counters 0.

Source files
------------

// File: rtl/tl_rx_credits_received_tracker_pkg.sv
// Shared definitions for the receive-side CREDITS_RECEIVED tracker:
// buffer type encodings, FSM states and credit arithmetic constants.
package tl_rx_credits_received_tracker_pkg;

  typedef enum logic [1:0] {
    TYP_P    = 2'b00,
    TYP_NP   = 2'b01,
    TYP_CPL  = 2'b10,
    TYP_NONE = 2'b11
  } buffer_typ_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam int DW_PER_DATA_CREDIT = 4;
  localparam int MAX_PAYLOAD_DW     = 1024;
  // Widest per-TLP data cost is 1024/4 = 256, which needs 9 bits.
  localparam int DATA_CREDS_WIDTH   = 9;

endpackage

// File: rtl/tl_rx_rcv_credit_counter.sv
// One header/data CREDITS_RECEIVED counter pair for a single FC type.
// Counters wrap modulo 2^width; clear and reset zero both.
module tl_rx_rcv_credit_counter
  import tl_rx_credits_received_tracker_pkg::*;
#(
  parameter int HDR_WIDTH  = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        add_en,
  input  logic [DATA_CREDS_WIDTH-1:0] data_creds,
  output logic [HDR_WIDTH-1:0]        hdr,
  output logic [DATA_WIDTH-1:0]       data
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hdr  <= '0;
      data <= '0;
    end else if (add_en) begin
      hdr  <= hdr + HDR_WIDTH'(1);
      data <= data + DATA_WIDTH'(data_creds);
    end
  end

endmodule

// File: rtl/tl_rx_credits_received_tracker.sv
// Tracks PCIe receive CREDITS_RECEIVED per FC type from TLP start/end events.
// Define TL_RX_RCV_DROP_STATS_EN to add the saturating drop_count output.
module tl_rx_credits_received_tracker
  import tl_rx_credits_received_tracker_pkg::*;
#(
  parameter int BUFFER_IN_DW_WIDTH   = 10,
  parameter int RCV_HDR_CREDS_WIDTH  = 12,
  parameter int RCV_DATA_CREDS_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tlp_start,
  input  logic [1:0]                      buffer_typ,
  input  logic                            tlp_has_data,
  input  logic [BUFFER_IN_DW_WIDTH-1:0]   buffer_in_dw,
  input  logic                            tlp_end,
  input  logic                            tlp_drop,
  input  logic                            fc_init,
  output logic [RCV_HDR_CREDS_WIDTH-1:0]  p_rcv_hdr,
  output logic [RCV_HDR_CREDS_WIDTH-1:0]  np_rcv_hdr,
  output logic [RCV_HDR_CREDS_WIDTH-1:0]  cpl_rcv_hdr,
  output logic [RCV_DATA_CREDS_WIDTH-1:0] p_rcv_data,
  output logic [RCV_DATA_CREDS_WIDTH-1:0] np_rcv_data,
  output logic [RCV_DATA_CREDS_WIDTH-1:0] cpl_rcv_data,
  output logic [1:0]                      pending_typ,
  output logic [DATA_CREDS_WIDTH-1:0]     pending_data_creds,
  output logic                            busy,
  output logic                            protocol_error
`ifdef TL_RX_RCV_DROP_STATS_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  // Two spare bits: one for the 1024-DW encoding, one for the rounding add.
  localparam int LEN_WIDTH = BUFFER_IN_DW_WIDTH + 2;

  state_e                      state;
  logic [LEN_WIDTH-1:0]        len_dw;
  logic [DATA_CREDS_WIDTH-1:0] start_creds;
  logic                        start_valid;
  logic                        commit;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    len_dw      = LEN_WIDTH'(buffer_in_dw);
    start_creds = '0;
    if (buffer_in_dw == '0) len_dw = LEN_WIDTH'(MAX_PAYLOAD_DW);
    if (tlp_has_data)
      start_creds = DATA_CREDS_WIDTH'((len_dw + LEN_WIDTH'(DW_PER_DATA_CREDIT - 1))
                                      / LEN_WIDTH'(DW_PER_DATA_CREDIT));
  end

  assign start_valid = tlp_start && (buffer_typ != TYP_NONE);
  assign commit      = (state == ST_PENDING) && tlp_end && !tlp_drop && !fc_init;
  assign busy        = (state == ST_PENDING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      pending_typ        <= TYP_NONE;
      pending_data_creds <= '0;
      protocol_error     <= 1'b0;
    end else begin
      protocol_error <= 1'b0;
      if (fc_init) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tlp_end) begin
              protocol_error <= 1'b1;
            end else if (start_valid) begin
              pending_typ        <= buffer_typ;
              pending_data_creds <= start_creds;
              state              <= ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (tlp_end) begin
              // A start in the same cycle chains the next TLP with no bubble.
              if (start_valid) begin
                pending_typ        <= buffer_typ;
                pending_data_creds <= start_creds;
              end
              state <= start_valid ? ST_PENDING : ST_IDLE;
            end else if (tlp_start) begin
              protocol_error <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  tl_rx_rcv_credit_counter #(
    .HDR_WIDTH (RCV_HDR_CREDS_WIDTH),
    .DATA_WIDTH(RCV_DATA_CREDS_WIDTH)
  ) u_p_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (fc_init),
    .add_en    (commit && (pending_typ == TYP_P)),
    .data_creds(pending_data_creds),
    .hdr       (p_rcv_hdr),
    .data      (p_rcv_data)
  );

  tl_rx_rcv_credit_counter #(
    .HDR_WIDTH (RCV_HDR_CREDS_WIDTH),
    .DATA_WIDTH(RCV_DATA_CREDS_WIDTH)
  ) u_np_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (fc_init),
    .add_en    (commit && (pending_typ == TYP_NP)),
    .data_creds(pending_data_creds),
    .hdr       (np_rcv_hdr),
    .data      (np_rcv_data)
  );

  tl_rx_rcv_credit_counter #(
    .HDR_WIDTH (RCV_HDR_CREDS_WIDTH),
    .DATA_WIDTH(RCV_DATA_CREDS_WIDTH)
  ) u_cpl_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (fc_init),
    .add_en    (commit && (pending_typ == TYP_CPL)),
    .data_creds(pending_data_creds),
    .hdr       (cpl_rcv_hdr),
    .data      (cpl_rcv_data)
  );

`ifdef TL_RX_RCV_DROP_STATS_EN
  logic drop_evt;
  assign drop_evt = (state == ST_PENDING) && tlp_end && tlp_drop && !fc_init;

  always_ff @(posedge clk) begin
    if (rst || fc_init) begin
      drop_count <= '0;
    end else if (drop_evt && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_rx_credits_received_tracker.sv
// Randomized self-checking bench for tl_rx_credits_received_tracker against
// a per-type credit-sum reference model.
module tb_tl_rx_credits_received_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlp_start;
  logic [1:0]  buffer_typ;
  logic        tlp_has_data;
  logic [9:0]  buffer_in_dw;
  logic        tlp_end;
  logic        tlp_drop;
  logic        fc_init;
  logic [11:0] p_rcv_hdr, np_rcv_hdr, cpl_rcv_hdr;
  logic [15:0] p_rcv_data, np_rcv_data, cpl_rcv_data;
  logic [1:0]  pending_typ;
  logic [8:0]  pending_data_creds;
  logic        busy;
  logic        protocol_error;
`ifdef TL_RX_RCV_DROP_STATS_EN
  logic [15:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: running credit sums per type, plus drop tally.
  int mdl_hdr  [3];
  int mdl_data [3];
  int mdl_drop;

  logic [11:0] got_hdr  [3];
  logic [15:0] got_data [3];
  assign got_hdr[0]  = p_rcv_hdr;
  assign got_hdr[1]  = np_rcv_hdr;
  assign got_hdr[2]  = cpl_rcv_hdr;
  assign got_data[0] = p_rcv_data;
  assign got_data[1] = np_rcv_data;
  assign got_data[2] = cpl_rcv_data;

  always #5 clk = ~clk;

  tl_rx_credits_received_tracker dut (
    .clk               (clk),
    .rst               (rst),
    .tlp_start         (tlp_start),
    .buffer_typ        (buffer_typ),
    .tlp_has_data      (tlp_has_data),
    .buffer_in_dw      (buffer_in_dw),
    .tlp_end           (tlp_end),
    .tlp_drop          (tlp_drop),
    .fc_init           (fc_init),
    .p_rcv_hdr         (p_rcv_hdr),
    .np_rcv_hdr        (np_rcv_hdr),
    .cpl_rcv_hdr       (cpl_rcv_hdr),
    .p_rcv_data        (p_rcv_data),
    .np_rcv_data       (np_rcv_data),
    .cpl_rcv_data      (cpl_rcv_data),
    .pending_typ       (pending_typ),
    .pending_data_creds(pending_data_creds),
    .busy              (busy),
    .protocol_error    (protocol_error)
`ifdef TL_RX_RCV_DROP_STATS_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  function automatic int cost(bit has_data, int len);
    int l;
    if (!has_data) return 0;
    l = (len == 0) ? 1024 : len;
    return (l + 3) / 4;
  endfunction

  task automatic idle_inputs();
    tlp_start    = 1'b0;
    buffer_typ   = 2'b11;
    tlp_has_data = 1'b0;
    buffer_in_dw = '0;
    tlp_end      = 1'b0;
    tlp_drop     = 1'b0;
    fc_init      = 1'b0;
  endtask

  task automatic mdl_clear();
    for (int t = 0; t < 3; t++) begin
      mdl_hdr[t]  = 0;
      mdl_data[t] = 0;
    end
    mdl_drop = 0;
  endtask

  task automatic mdl_end(int typ, bit has_data, int len, bit drop);
    if (drop) begin
      if (mdl_drop < 65535) mdl_drop++;
    end else begin
      mdl_hdr[typ]  = (mdl_hdr[typ] + 1) % 4096;
      mdl_data[typ] = (mdl_data[typ] + cost(has_data, len)) % 65536;
    end
  endtask

  task automatic drive_start(int typ, bit has_data, int len);
    tlp_start    = 1'b1;
    buffer_typ   = 2'(typ);
    tlp_has_data = has_data;
    buffer_in_dw = 10'(len);
  endtask

  // Full TLP: start, then end one cycle later; returns aligned after the commit edge.
  task automatic send_tlp(int typ, bit has_data, int len, bit drop);
    drive_start(typ, has_data, len);
    @(negedge clk);
    tlp_start = 1'b0;
    tlp_end   = 1'b1;
    tlp_drop  = drop;
    mdl_end(typ, has_data, len, drop);
    @(negedge clk);
    tlp_end  = 1'b0;
    tlp_drop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    mdl_clear();
    for (int t = 0; t < 3; t++) begin
      total++;
      if (got_hdr[t] !== 12'd0) begin
        bad++; $display("FAIL reset_hdr[%0d]: got %0h want 0", t, got_hdr[t]);
      end
      total++;
      if (got_data[t] !== 16'd0) begin
        bad++; $display("FAIL reset_data[%0d]: got %0h want 0", t, got_data[t]);
      end
    end
    total++;
    if ({pending_typ, pending_data_creds, busy, protocol_error} !== {2'b11, 9'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_status: typ=%0d creds=%0d busy=%0b perr=%0b want 3/0/0/0",
               pending_typ, pending_data_creds, busy, protocol_error);
    end
`ifdef TL_RX_RCV_DROP_STATS_EN
    total++;
    if (drop_count !== 16'd0) begin
      bad++; $display("FAIL reset_drop_count: got %0d want 0", drop_count);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_p_len5();
    drive_start(0, 1'b1, 5);
    @(negedge clk);
    tlp_start = 1'b0;
    tlp_end   = 1'b1;
    total++;
    if ({busy, pending_typ, pending_data_creds, p_rcv_hdr, p_rcv_data} !== {1'b1, 2'd0, 9'd2, 12'd0, 16'd0}) begin
      bad++;
      $display("FAIL p5_pending: busy=%0b typ=%0d creds=%0d hdr=%0d data=%0d want 1/0/2/0/0",
               busy, pending_typ, pending_data_creds, p_rcv_hdr, p_rcv_data);
    end
    mdl_end(0, 1'b1, 5, 1'b0);
    @(negedge clk);
    tlp_end = 1'b0;
    total++;
    if ({p_rcv_hdr, p_rcv_data} !== {12'd1, 16'd2}) begin
      bad++; $display("FAIL p5_commit: hdr=%0d data=%0d want 1/2", p_rcv_hdr, p_rcv_data);
    end
    total++;
    if ({np_rcv_hdr, np_rcv_data, cpl_rcv_hdr, cpl_rcv_data, busy} !== 57'd0) begin
      bad++;
      $display("FAIL p5_others: np=%0d/%0d cpl=%0d/%0d busy=%0b want all 0",
               np_rcv_hdr, np_rcv_data, cpl_rcv_hdr, cpl_rcv_data, busy);
    end
  endtask

  task automatic test_np_cpl();
    send_tlp(1, 1'b1, 0, 1'b0);
    total++;
    if ({np_rcv_hdr, np_rcv_data} !== {12'd1, 16'd256}) begin
      bad++; $display("FAIL np_len1024: hdr=%0d data=%0d want 1/256", np_rcv_hdr, np_rcv_data);
    end
    send_tlp(2, 1'b0, 17, 1'b0);
    total++;
    if ({cpl_rcv_hdr, cpl_rcv_data} !== {12'd1, 16'd0}) begin
      bad++; $display("FAIL cpl_nodata: hdr=%0d data=%0d want 1/0", cpl_rcv_hdr, cpl_rcv_data);
    end
    for (int t = 0; t < 3; t++) begin
      total++;
      if ({got_hdr[t], got_data[t]} !== {12'(mdl_hdr[t]), 16'(mdl_data[t])}) begin
        bad++;
        $display("FAIL np_cpl_model[%0d]: got %0d/%0d want %0d/%0d",
                 t, got_hdr[t], got_data[t], mdl_hdr[t], mdl_data[t]);
      end
    end
  endtask

  task automatic test_drop();
    send_tlp(2, 1'b1, 8, 1'b1);
    for (int t = 0; t < 3; t++) begin
      total++;
      if ({got_hdr[t], got_data[t]} !== {12'(mdl_hdr[t]), 16'(mdl_data[t])}) begin
        bad++;
        $display("FAIL drop_unchanged[%0d]: got %0d/%0d want %0d/%0d",
                 t, got_hdr[t], got_data[t], mdl_hdr[t], mdl_data[t]);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL drop_busy: got %0b want 0", busy);
    end
`ifdef TL_RX_RCV_DROP_STATS_EN
    total++;
    if (drop_count !== 16'd1) begin
      bad++; $display("FAIL drop_count: got %0d want 1", drop_count);
    end
`endif
  endtask

  task automatic test_wrap();
    fc_init = 1'b1;
    @(negedge clk);
    fc_init = 1'b0;
    mdl_clear();
    // 255 * 256 + 255 = 0xFFFF data credits on P.
    for (int i = 0; i < 255; i++) send_tlp(0, 1'b1, 0, 1'b0);
    send_tlp(0, 1'b1, 1020, 1'b0);
    total++;
    if (p_rcv_data !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_preset: got %0h want ffff", p_rcv_data);
    end
    send_tlp(0, 1'b1, 4, 1'b0);
    total++;
    if ({p_rcv_hdr, p_rcv_data} !== {12'd257, 16'h0000}) begin
      bad++; $display("FAIL wrap_result: hdr=%0d data=%0h want 257/0", p_rcv_hdr, p_rcv_data);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(0, 1'b1, 8);
    @(negedge clk);
    tlp_end = 1'b1;
    mdl_end(0, 1'b1, 8, 1'b0);
    drive_start(1, 1'b1, 12);
    @(negedge clk);
    tlp_start = 1'b0;
    total++;
    if ({busy, pending_typ, pending_data_creds} !== {1'b1, 2'd1, 9'd3}) begin
      bad++;
      $display("FAIL b2b_chain: busy=%0b typ=%0d creds=%0d want 1/1/3",
               busy, pending_typ, pending_data_creds);
    end
    total++;
    if ({p_rcv_hdr, p_rcv_data} !== {12'(mdl_hdr[0]), 16'(mdl_data[0])}) begin
      bad++;
      $display("FAIL b2b_first: got %0d/%0d want %0d/%0d",
               p_rcv_hdr, p_rcv_data, mdl_hdr[0], mdl_data[0]);
    end
    mdl_end(1, 1'b1, 12, 1'b0);
    @(negedge clk);
    tlp_end = 1'b0;
    total++;
    if ({busy, np_rcv_hdr, np_rcv_data} !== {1'b0, 12'(mdl_hdr[1]), 16'(mdl_data[1])}) begin
      bad++;
      $display("FAIL b2b_second: busy=%0b np=%0d/%0d want 0/%0d/%0d",
               busy, np_rcv_hdr, np_rcv_data, mdl_hdr[1], mdl_data[1]);
    end
  endtask

  task automatic test_protocol_error();
    drive_start(2, 1'b1, 8);
    @(negedge clk);
    drive_start(0, 1'b1, 40);
    @(negedge clk);
    tlp_start = 1'b0;
    total++;
    if ({protocol_error, busy, pending_typ, pending_data_creds} !== {1'b1, 1'b1, 2'd2, 9'd2}) begin
      bad++;
      $display("FAIL perr_start: perr=%0b busy=%0b typ=%0d creds=%0d want 1/1/2/2",
               protocol_error, busy, pending_typ, pending_data_creds);
    end
    @(negedge clk);
    total++;
    if (protocol_error !== 1'b0) begin
      bad++; $display("FAIL perr_single_pulse: got %0b want 0", protocol_error);
    end
    tlp_end = 1'b1;
    mdl_end(2, 1'b1, 8, 1'b0);
    @(negedge clk);
    total++;
    if ({cpl_rcv_hdr, cpl_rcv_data, p_rcv_hdr} !== {12'(mdl_hdr[2]), 16'(mdl_data[2]), 12'(mdl_hdr[0])}) begin
      bad++;
      $display("FAIL perr_commit: cpl=%0d/%0d p_hdr=%0d want %0d/%0d/%0d",
               cpl_rcv_hdr, cpl_rcv_data, p_rcv_hdr, mdl_hdr[2], mdl_data[2], mdl_hdr[0]);
    end
    // tlp_end with nothing in flight.
    @(negedge clk);
    tlp_end = 1'b0;
    total++;
    if ({protocol_error, busy, cpl_rcv_hdr} !== {1'b1, 1'b0, 12'(mdl_hdr[2])}) begin
      bad++;
      $display("FAIL perr_idle_end: perr=%0b busy=%0b cpl_hdr=%0d want 1/0/%0d",
               protocol_error, busy, cpl_rcv_hdr, mdl_hdr[2]);
    end
    @(negedge clk);
    total++;
    if (protocol_error !== 1'b0) begin
      bad++; $display("FAIL perr_idle_clear: got %0b want 0", protocol_error);
    end
  endtask

  task automatic test_fc_init();
    drive_start(0, 1'b1, 100);
    @(negedge clk);
    tlp_start = 1'b0;
    tlp_end   = 1'b1;
    fc_init   = 1'b1;
    @(negedge clk);
    tlp_end = 1'b0;
    fc_init = 1'b0;
    mdl_clear();
    for (int t = 0; t < 3; t++) begin
      total++;
      if ({got_hdr[t], got_data[t]} !== 28'd0) begin
        bad++; $display("FAIL fcinit_clear[%0d]: got %0d/%0d want 0/0", t, got_hdr[t], got_data[t]);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL fcinit_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    send_tlp(1, 1'b1, 9, 1'b0);
    drive_start(1, 1'b1, 33);
    @(negedge clk);
    tlp_start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
    total++;
    if ({busy, pending_typ, pending_data_creds, protocol_error} !== {1'b0, 2'b11, 9'd0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_status: busy=%0b typ=%0d creds=%0d perr=%0b want 0/3/0/0",
               busy, pending_typ, pending_data_creds, protocol_error);
    end
    for (int t = 0; t < 3; t++) begin
      total++;
      if ({got_hdr[t], got_data[t]} !== 28'd0) begin
        bad++; $display("FAIL rst_mid_counters[%0d]: got %0d/%0d want 0/0", t, got_hdr[t], got_data[t]);
      end
    end
  endtask

  task automatic test_random();
    bit in_fl = 1'b0;
    int f_typ = 0, f_hd = 0, f_len = 0;
    int r;
    bit drop;
    for (int it = 0; it < 600; it++) begin
      idle_inputs();
      if (in_fl) begin
        if ($urandom_range(0, 3) != 0) begin
          drop     = ($urandom_range(0, 3) == 0);
          tlp_end  = 1'b1;
          tlp_drop = drop;
          mdl_end(f_typ, f_hd[0], f_len, drop);
          in_fl = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            f_typ = $urandom_range(0, 2);
            f_hd  = $urandom_range(0, 1);
            f_len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 1023);
            drive_start(f_typ, f_hd[0], f_len);
            in_fl = 1'b1;
          end
        end
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          f_typ = $urandom_range(0, 2);
          f_hd  = $urandom_range(0, 1);
          f_len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 1023);
          drive_start(f_typ, f_hd[0], f_len);
          in_fl = 1'b1;
        end else if (r == 6) begin
          drive_start(3, 1'b1, $urandom_range(0, 1023));
        end
      end
      @(negedge clk);
      total++;
      if (busy !== in_fl) begin
        bad++; $display("FAIL rnd_busy it=%0d: got %0b want %0b", it, busy, in_fl);
      end
      if (in_fl) begin
        total++;
        if ({pending_typ, pending_data_creds} !== {2'(f_typ), 9'(cost(f_hd[0], f_len))}) begin
          bad++;
          $display("FAIL rnd_pending it=%0d: typ=%0d creds=%0d want %0d/%0d",
                   it, pending_typ, pending_data_creds, f_typ, cost(f_hd[0], f_len));
        end
      end
      for (int t = 0; t < 3; t++) begin
        total++;
        if ({got_hdr[t], got_data[t]} !== {12'(mdl_hdr[t]), 16'(mdl_data[t])}) begin
          bad++;
          $display("FAIL rnd_counters it=%0d typ=%0d: got %0d/%0d want %0d/%0d",
                   it, t, got_hdr[t], got_data[t], mdl_hdr[t], mdl_data[t]);
        end
      end
`ifdef TL_RX_RCV_DROP_STATS_EN
      total++;
      if (drop_count !== 16'(mdl_drop)) begin
        bad++; $display("FAIL rnd_drop_count it=%0d: got %0d want %0d", it, drop_count, mdl_drop);
      end
`endif
    end
    if (in_fl) begin
      idle_inputs();
      tlp_end = 1'b1;
      mdl_end(f_typ, f_hd[0], f_len, 1'b0);
      @(negedge clk);
      tlp_end = 1'b0;
    end
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      total++;
      if ({got_hdr[t], got_data[t]} !== {12'(mdl_hdr[t]), 16'(mdl_data[t])}) begin
        bad++;
        $display("FAIL rnd_final typ=%0d: got %0d/%0d want %0d/%0d",
                 t, got_hdr[t], got_data[t], mdl_hdr[t], mdl_data[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_p_len5();
    test_np_cpl();
    test_drop();
    test_wrap();
    test_back_to_back();
    test_protocol_error();
    test_fc_init();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
